// File: rtl/xconf_mem_ctrl.sv
// Configuration memory controller: saves conf_out snapshots into word-serial slot storage
// and loads a slot back onto conf_in with a single-cycle conf_ld strobe.
module xconf_mem_ctrl #(
    parameter int CONF_BITS = 640,
    parameter int WORD_W    = 32,
    parameter int N_SLOTS   = 16,
    parameter int SLOT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctr_valid,
    input  logic                 ctr_we,
    input  logic [1:0]           ctr_addr,
    input  logic [SLOT_W-1:0]    ctr_data_in,
    output logic [1:0]           ctr_data_out,
    output logic                 busy,
    input  logic [CONF_BITS-1:0] conf_out,
    output logic [CONF_BITS-1:0] conf_in,
    output logic                 conf_ld
);

    localparam int NWORDS = (CONF_BITS + WORD_W - 1) / WORD_W;
    localparam int TOT_W  = NWORDS * WORD_W;
    localparam int DEPTH  = N_SLOTS * NWORDS;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_END     = CNT_W'(NWORDS);
    localparam logic [SLOT_W:0]   SLOT_LIM    = (SLOT_W + 1)'(N_SLOTS);
    localparam logic [1:0]        ADDR_SAVE   = 2'd0;
    localparam logic [1:0]        ADDR_LOAD   = 2'd1;
    localparam logic [1:0]        ADDR_STATUS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic [SLOT_W-1:0]   slot_r;
    logic [TOT_W-1:0]    snap_r;
    logic [TOT_W-1:0]    asm_r;
    logic                busy_r, busy_nx_s;
    logic                conf_ld_r, conf_ld_nx_s;
    logic                err_r, err_nx_s;
    logic [1:0]          status_r;

    logic [WORD_W-1:0]   mem_r [DEPTH];
    logic [WORD_W-1:0]   rdata_r;
    logic                mem_we_s;
    logic [AW-1:0]       mem_addr_s;
    logic [WORD_W-1:0]   mem_wdata_s;
    logic [AW-1:0]       base_addr_s;
    logic [IW-1:0]       wd_idx_s;
    logic [IW-1:0]       cap_idx_s;

    logic cmd_s, accept_s, reject_s, stat_wr_s, stat_rd_s;

    assign cmd_s     = ctr_valid & ctr_we & ((ctr_addr == ADDR_SAVE) | (ctr_addr == ADDR_LOAD));
    assign accept_s  = cmd_s & (state_r == ST_IDLE) & ({1'b0, ctr_data_in} < SLOT_LIM);
    assign reject_s  = cmd_s & ~accept_s;
    assign stat_wr_s = ctr_valid & ctr_we & (ctr_addr == ADDR_STATUS);
    assign stat_rd_s = ctr_valid & ~ctr_we & (ctr_addr == ADDR_STATUS);

    // Word address inside the slot region; only driven onto the RAM while in range.
    assign base_addr_s = AW'(slot_r) * AW'(NWORDS) + AW'(cnt_r);
    assign wd_idx_s    = IW'(cnt_r);
    assign cap_idx_s   = IW'(cnt_r - CNT_W'(1));

    // Next-state, sequencing counter and RAM port control.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        busy_nx_s    = busy_r;
        conf_ld_nx_s = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = (ctr_addr == ADDR_SAVE) ? ST_SAVE : ST_LOAD;
                    cnt_nx_s   = '0;
                    busy_nx_s  = 1'b1;
                end else begin
                    busy_nx_s  = 1'b0;
                end
            end
            ST_SAVE: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = base_addr_s;
                mem_wdata_s = snap_r[wd_idx_s * WORD_W +: WORD_W];
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                    busy_nx_s  = 1'b0;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (cnt_r < CNT_END) begin
                    mem_addr_s = base_addr_s;
                end else begin
                    mem_addr_s = '0;
                end
                // One extra cycle lets the last read word land in the assembly buffer.
                if (cnt_r == CNT_END) begin
                    state_nx_s   = ST_DONE;
                    cnt_nx_s     = '0;
                    conf_ld_nx_s = 1'b1;
                end else begin
                    cnt_nx_s     = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // Sticky error: a reject in the same cycle as a status write wins.
    always_comb begin
        if (reject_s) begin
            err_nx_s = 1'b1;
        end else if (stat_wr_s) begin
            err_nx_s = 1'b0;
        end else begin
            err_nx_s = err_r;
        end
    end

    // Control state, status and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            conf_ld_r <= 1'b0;
            err_r     <= 1'b0;
            status_r  <= 2'b00;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            busy_r    <= busy_nx_s;
            conf_ld_r <= conf_ld_nx_s;
            err_r     <= err_nx_s;
            if (stat_rd_s) begin
                status_r <= {err_r, busy_r};
            end
        end
    end

    // Slot latch, SAVE snapshot and LOAD assembly buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= '0;
            snap_r <= '0;
            asm_r  <= '0;
        end else begin
            if (accept_s) begin
                slot_r <= ctr_data_in;
                if (ctr_addr == ADDR_SAVE) begin
                    snap_r <= TOT_W'(conf_out);
                end
            end
            if ((state_r == ST_LOAD) && (cnt_r != '0)) begin
                asm_r[cap_idx_s * WORD_W +: WORD_W] <= rdata_r;
            end
        end
    end

    // Single-port slot RAM with synchronous read; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
        rdata_r <= mem_r[mem_addr_s];
    end

    assign busy         = busy_r;
    assign conf_ld      = conf_ld_r;
    assign conf_in      = asm_r[CONF_BITS-1:0];
    assign ctr_data_out = status_r;

endmodule
